// File: rtl/i2c_cmd_queue.sv
// Command FIFO in front of a byte-level I2C controller: issues one queued
// command at a time, supervises completion with a timeout and returns a response.
module i2c_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [6:0]               cmd_addr,
  input  logic                     cmd_rw,
  input  logic [7:0]               cmd_wdata,
  output logic                     new_dat,
  output logic [6:0]               addr,
  output logic                     r_w,
  output logic [7:0]               dat_in,
  input  logic [7:0]               dat_out,
  input  logic                     busy,
  input  logic                     ack_err,
  input  logic                     done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_e;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic          new_dat_q, new_dat_d;
  logic [6:0]    addr_q, addr_d;
  logic          r_w_q, r_w_d;
  logic [7:0]    dat_in_q, dat_in_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [31:0]   timer_q, timer_d;
  logic          sticky_q, sticky_d;
  logic          push_s, pop_s;
  logic [EW-1:0] head_s;

  // cmd_ready comes straight from the registered count, so a pop cannot free a slot early
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push_s    = cmd_valid && cmd_ready;
  assign pop_s     = (state_q == IDLE) && (count_q != {CW{1'b0}}) && !busy && !rsp_valid_q;
  assign head_s    = mem_q[rd_ptr_q];

  assign new_dat     = new_dat_q;
  assign addr        = addr_q;
  assign r_w         = r_w_q;
  assign dat_in      = dat_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign level       = count_q;

  // FIFO storage, packed as {addr, rw, wdata}
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_addr, cmd_rw, cmd_wdata};
    end
  end

  // Next-state and output logic for the FIFO pointers and the issue FSM
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    new_dat_d     = 1'b0;
    addr_d        = addr_q;
    r_w_d         = r_w_q;
    dat_in_d      = dat_in_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_d       = timer_q;
    sticky_d      = sticky_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop_s) begin
          rd_ptr_d  = rd_ptr_q + PW'(1);
          addr_d    = head_s[15:9];
          r_w_d     = head_s[8];
          dat_in_d  = head_s[7:0];
          new_dat_d = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        timer_d  = 32'd0;
        sticky_d = 1'b0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        sticky_d = sticky_q | ack_err;
        // done is checked first so it wins over a coinciding timeout
        if (done) begin
          rsp_data_d    = r_w_q ? dat_out : 8'h00;
          rsp_err_d     = sticky_q | ack_err;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (timer_q == 32'(TIMEOUT - 1)) begin
          rsp_data_d    = 8'h00;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          timer_d = timer_q + 32'd1;
          state_d = WAIT_DONE;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = RESP;
        end else if (!rsp_valid_q && !done) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
      new_dat_q     <= 1'b0;
      addr_q        <= 7'h00;
      r_w_q         <= 1'b0;
      dat_in_q      <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      timer_q       <= 32'd0;
      sticky_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      new_dat_q     <= new_dat_d;
      addr_q        <= addr_d;
      r_w_q         <= r_w_d;
      dat_in_q      <= dat_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      timer_q       <= timer_d;
      sticky_q      <= sticky_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Directed and randomized checks of i2c_cmd_queue against a transaction-level model.
module tb_i2c_cmd_queue;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       new_dat, r_w;
  logic [6:0] addr;
  logic [7:0] dat_in, dat_out;
  logic       busy, ack_err, done;
  logic       rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [7:0] rsp_data;
  logic [2:0] level;

  int n_assert = 0;
  int n_fail   = 0;

  i2c_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .new_dat(new_dat), .addr(addr), .r_w(r_w), .dat_in(dat_in),
    .dat_out(dat_out), .busy(busy), .ack_err(ack_err), .done(done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_wdata = 8'h00;
    busy = 1'b0; ack_err = 1'b0; done = 1'b0; dat_out = 8'h00; rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_new_dat(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (new_dat) seen = 1'b1;
      else step();
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [15:0] mq[$];
  logic [15:0] exp_cmd;
  int          ctl_st, ctl_k, ctl_lat, nd_cnt, n;
  logic        ctl_rw, ctl_err, ev, ee, et, ne, nt, resp_due, acc, hs, drain;
  logic [7:0]  ed, ndata;
  bit          seen;

  initial begin
    idle_inputs();
    do_reset();
    chk("reset_level", level, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_new_dat", new_dat, 0);
    chk("reset_outputs", {addr, r_w, dat_in}, 0);
    chk("reset_rsp", {rsp_valid, rsp_data, rsp_err, rsp_timeout}, 0);

    // write, exact issue latency
    dat_out = 8'hFF;
    push(7'h50, 1'b0, 8'hA5);
    chk("wr_level_after_push", level, 1);
    chk("wr_no_bypass", new_dat, 0);
    step();
    chk("wr_new_dat_n2", new_dat, 1);
    chk("wr_issue_fields", {addr, r_w, dat_in}, {7'h50, 1'b0, 8'hA5});
    chk("wr_level_after_pop", level, 0);
    step();
    chk("wr_new_dat_one_cycle", new_dat, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("wr_rsp", {rsp_valid, rsp_data, rsp_err, rsp_timeout}, {1'b1, 8'h00, 1'b0, 1'b0});
    chk("wr_fields_hold", {addr, r_w, dat_in}, {7'h50, 1'b0, 8'hA5});
    handshake();
    chk("wr_rsp_cleared", rsp_valid, 0);
    chk("wr_rsp_data_hold", {rsp_data, rsp_err}, 0);

    // read with NACK in WAIT_DONE
    push(7'h21, 1'b1, 8'h00);
    wait_new_dat(4, seen);
    chk("nack_issue_seen", seen, 1);
    step();
    ack_err = 1'b1;
    step();
    ack_err = 1'b0;
    step();
    dat_out = 8'h3C; done = 1'b1;
    step();
    done = 1'b0;
    chk("nack_rsp", {rsp_valid, rsp_data, rsp_err, rsp_timeout}, {1'b1, 8'h3C, 1'b1, 1'b0});
    handshake();

    // timeout latency
    push(7'h33, 1'b1, 8'h77);
    wait_new_dat(4, seen);
    chk("tmo_issue_seen", seen, 1);
    step();
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("tmo_latency", n, TMO);
    chk("tmo_rsp", {rsp_valid, rsp_data, rsp_err, rsp_timeout}, {1'b1, 8'h00, 1'b1, 1'b1});
    handshake();

    // done coinciding with the last timer cycle
    push(7'h44, 1'b1, 8'h00);
    wait_new_dat(4, seen);
    chk("coin_issue_seen", seen, 1);
    step();
    repeat (TMO - 1) step();
    chk("coin_not_yet", rsp_valid, 0);
    dat_out = 8'h96; done = 1'b1;
    step();
    done = 1'b0;
    chk("coin_rsp", {rsp_valid, rsp_data, rsp_err, rsp_timeout}, {1'b1, 8'h96, 1'b0, 1'b0});
    handshake();

    // full queue and back-pressure
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_addr = 7'(7'h60 + i); cmd_rw = 1'b0; cmd_wdata = 8'(i);
      step();
    end
    chk("full_level", level, 4);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_first_issued", addr, 7'h60);
    cmd_addr = 7'h6F;
    step();
    step();
    chk("full_push_held", level, 4);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("full_rsp_valid", rsp_valid, 1);
    nd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (new_dat) nd_cnt++;
    end
    chk("full_no_issue_pending", nd_cnt, 0);
    chk("full_level_pending", level, 4);
    handshake();
    chk("full_rsp_cleared", rsp_valid, 0);
    wait_new_dat(6, seen);
    chk("full_next_issue_seen", seen, 1);
    chk("full_next_addr", addr, 7'h61);
    chk("full_level_after_pop", level, 3);
    step();
    cmd_valid = 1'b0;
    chk("full_sixth_accepted", level, 4);

    // reset mid-transaction with three queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_addr = 7'(7'h10 + i); cmd_rw = 1'b1; cmd_wdata = 8'h00;
      step();
    end
    cmd_valid = 1'b0;
    chk("rstmid_level_before", level, 3);
    rst = 1'b0;
    step();
    chk("rstmid_state", {level, rsp_valid, new_dat, cmd_ready}, {3'd0, 1'b0, 1'b0, 1'b1});
    rst = 1'b1;
    nd_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (new_dat) nd_cnt++;
    end
    chk("rstmid_no_issue", nd_cnt, 0);

    // randomized traffic against the transaction model
    idle_inputs();
    do_reset();
    mq.delete();
    ctl_st = 0; ctl_k = 0; ctl_lat = 0; ctl_rw = 1'b0; ctl_err = 1'b0;
    ev = 1'b0; ed = 8'h00; ee = 1'b0; et = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      drain = (cyc >= 3000);
      if (new_dat) begin
        chk("rnd_issue_allowed", {31'd0, (ctl_st == 0 && !ev && mq.size() > 0)}, 1);
        if (mq.size() > 0) begin
          exp_cmd = mq.pop_front();
          chk("rnd_issue_cmd", {addr, r_w, dat_in}, exp_cmd);
        end
        ctl_st = 1; ctl_rw = r_w; ctl_k = 0; ctl_err = 1'b0;
        ctl_lat = int'($urandom_range(1, 18));
      end
      chk("rnd_level", level, mq.size());
      chk("rnd_cmd_ready", cmd_ready, (mq.size() != DEPTH));
      chk("rnd_rsp", {rsp_valid, rsp_data, rsp_err, rsp_timeout}, {ev, ed, ee, et});
      if (drain && mq.size() == 0 && ctl_st == 0 && !ev) break;

      done = 1'b0; ack_err = 1'b0; dat_out = 8'($urandom); resp_due = 1'b0;
      ndata = 8'h00; ne = 1'b0; nt = 1'b0;
      if (ctl_st == 2) begin
        ctl_k++;
        ack_err = ($urandom_range(0, 3) == 0);
        ctl_err = ctl_err | ack_err;
        if (ctl_k == ctl_lat) begin
          done = 1'b1; ndata = ctl_rw ? dat_out : 8'h00; ne = ctl_err; nt = 1'b0;
          resp_due = 1'b1; ctl_st = 0;
        end else if (ctl_k == TMO) begin
          ndata = 8'h00; ne = 1'b1; nt = 1'b1; resp_due = 1'b1; ctl_st = 0;
        end
      end else if (ctl_st == 1) begin
        ctl_st = 2;
      end
      busy      = (ctl_st != 0) || ($urandom_range(0, 4) == 0);
      rsp_ready = drain ? 1'b1 : ($urandom_range(0, 1) == 1);
      cmd_valid = !drain && ($urandom_range(0, 1) == 1);
      cmd_addr  = 7'($urandom);
      cmd_rw    = 1'($urandom);
      cmd_wdata = 8'($urandom);
      acc = cmd_valid && (mq.size() != DEPTH);
      hs  = ev && rsp_ready;
      step();
      if (acc) mq.push_back({cmd_addr, cmd_rw, cmd_wdata});
      if (resp_due) begin
        ev = 1'b1; ed = ndata; ee = ne; et = nt;
      end else if (hs) begin
        ev = 1'b0;
      end
    end
    chk("rnd_drained", {31'd0, (mq.size() == 0 && ctl_st == 0 && !ev)}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
